hc_traffic_controller: RTL and testbench

//  Highway / country-road junction signal controller. Highway holds GREEN by

---
 rtl/hc_traffic_controller_pkg.sv | 27 ++
 rtl/hc_traffic_controller.sv | 74 +++++++
 tb/tb_hc_traffic_controller.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/hc_traffic_controller_pkg.sv
// Shared junction-controller definitions: one-hot lamp encodings and the
// five-state signal sequence used by the highway/country controllers.
package hc_traffic_controller_pkg;

   localparam logic [2:0] LAMP_RED    = 3'b100;
   localparam logic [2:0] LAMP_YELLOW = 3'b010;
   localparam logic [2:0] LAMP_GREEN  = 3'b001;

   typedef enum logic [2:0] {
      S0 = 3'd0,  // highway green, country red
      S1 = 3'd1,  // highway yellow
      S2 = 3'd2,  // all-red clearance
      S3 = 3'd3,  // country green
      S4 = 3'd4   // country yellow
   } state_e;

   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/hc_traffic_controller.sv
// Highway/country junction signal controller: Moore FSM with one shared
// dwell counter timing the yellow and all-red phases.
module hc_traffic_controller
   import hc_traffic_controller_pkg::*;
#(
   parameter int unsigned HWY_Y_CYC   = 1,
   parameter int unsigned ALL_R_CYC   = 1,
   parameter int unsigned CNTRY_Y_CYC = 1
) (
   input  logic       clock,
   input  logic       clear_n,
   input  logic       x,
   output logic [2:0] hwy,
   output logic [2:0] cntry
);

   localparam int unsigned MAX_DWELL = max3(HWY_Y_CYC, ALL_R_CYC, CNTRY_Y_CYC);
   localparam int unsigned CNT_W     = $clog2(MAX_DWELL) + 1;

   localparam logic [CNT_W-1:0] HWY_Y_LAST   = CNT_W'(HWY_Y_CYC - 1);
   localparam logic [CNT_W-1:0] ALL_R_LAST   = CNT_W'(ALL_R_CYC - 1);
   localparam logic [CNT_W-1:0] CNTRY_Y_LAST = CNT_W'(CNTRY_Y_CYC - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state_q <= S0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Counter defaults to zero so any state change clears it; it only
   // advances while a timed state is held.
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      case (state_q)
         S0: if (x) state_d = S1;
         S1: begin
            if (cnt_q == HWY_Y_LAST) state_d = S2;
            else                     cnt_d   = cnt_q + 1'b1;
         end
         S2: begin
            if (cnt_q == ALL_R_LAST) state_d = S3;
            else                     cnt_d   = cnt_q + 1'b1;
         end
         S3: if (!x) state_d = S4;
         S4: begin
            if (cnt_q == CNTRY_Y_LAST) state_d = S0;
            else                       cnt_d   = cnt_q + 1'b1;
         end
         default: state_d = S0;
      endcase
   end

   always_comb begin
      hwy   = LAMP_RED;
      cntry = LAMP_RED;
      case (state_q)
         S0: hwy   = LAMP_GREEN;
         S1: hwy   = LAMP_YELLOW;
         S2: ;
         S3: cntry = LAMP_GREEN;
         S4: cntry = LAMP_YELLOW;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_hc_traffic_controller.sv
// Bench for hc_traffic_controller: default and stretched-timing instances
// share stimulus; a countdown model feeds per-instance expectation queues.
module tb_hc_traffic_controller;

   logic       clock = 1'b0;
   logic       clear_n;
   logic       x;
   logic [2:0] hwy_d, cntry_d, hwy_o, cntry_o;

   int n_checks = 0;
   int n_errors = 0;

   hc_traffic_controller dut_def (
      .clock   (clock),
      .clear_n (clear_n),
      .x       (x),
      .hwy     (hwy_d),
      .cntry   (cntry_d)
   );

   hc_traffic_controller #(
      .HWY_Y_CYC   (3),
      .ALL_R_CYC   (2),
      .CNTRY_Y_CYC (4)
   ) dut_ovr (
      .clock   (clock),
      .clear_n (clear_n),
      .x       (x),
      .hwy     (hwy_o),
      .cntry   (cntry_o)
   );

   always #5 clock = ~clock;

   int py[2] = '{1, 3};
   int pr[2] = '{1, 2};
   int pc[2] = '{1, 4};

   int m_st[2];
   int m_left[2];
   int ry[2], rr[2], rc[2];

   logic [5:0] q_def[$];
   logic [5:0] q_ovr[$];

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [5:0] lamps(input int st);
      case (st)
         0:       return {3'b001, 3'b100};
         1:       return {3'b010, 3'b100};
         2:       return {3'b100, 3'b100};
         3:       return {3'b100, 3'b001};
         default: return {3'b100, 3'b010};
      endcase
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_st[d] = 0; m_left[d] = 0;
         ry[d] = 0; rr[d] = 0; rc[d] = 0;
      end
   endtask

   task automatic model_edge(input int d);
      if (!clear_n) begin
         m_st[d] = 0;
      end else begin
         case (m_st[d])
            0: if (x) begin m_st[d] = 1; m_left[d] = py[d]; end
            1: begin
               m_left[d]--;
               if (m_left[d] == 0) begin m_st[d] = 2; m_left[d] = pr[d]; end
            end
            2: begin
               m_left[d]--;
               if (m_left[d] == 0) m_st[d] = 3;
            end
            3: if (!x) begin m_st[d] = 4; m_left[d] = pc[d]; end
            default: begin
               m_left[d]--;
               if (m_left[d] == 0) m_st[d] = 0;
            end
         endcase
      end
   endtask

   task automatic sample_one(input int d);
      logic [5:0] got, exp;
      got = (d == 0) ? {hwy_d, cntry_d} : {hwy_o, cntry_o};
      if ((d == 0 && q_def.size() == 0) || (d == 1 && q_ovr.size() == 0)) begin
         check_eq("sb_empty", 1, 0);
         return;
      end
      exp = (d == 0) ? q_def.pop_front() : q_ovr.pop_front();
      check_eq(d == 0 ? "lamps_def" : "lamps_ovr", got, exp);
      check_eq("exclusive", (got[5:3] != 3'b100) && (got[2:0] != 3'b100), 0);
      if (got[5:3] == 3'b010) ry[d]++;
      else if (ry[d] > 0) begin
         check_eq(d == 0 ? "hwy_y_len_def" : "hwy_y_len_ovr", ry[d], py[d]);
         ry[d] = 0;
      end
      if (got == 6'b100100) rr[d]++;
      else if (rr[d] > 0) begin
         check_eq(d == 0 ? "all_r_len_def" : "all_r_len_ovr", rr[d], pr[d]);
         rr[d] = 0;
      end
      if (got[2:0] == 3'b010) rc[d]++;
      else if (rc[d] > 0) begin
         check_eq(d == 0 ? "cty_y_len_def" : "cty_y_len_ovr", rc[d], pc[d]);
         rc[d] = 0;
      end
   endtask

   // Drive x ahead of the next rising edge, predict its effect, sample on the falling edge.
   task automatic step(input logic xv);
      x = xv;
      for (int d = 0; d < 2; d++) model_edge(d);
      q_def.push_back(lamps(m_st[0]));
      q_ovr.push_back(lamps(m_st[1]));
      @(negedge clock);
      sample_one(0);
      sample_one(1);
   endtask

   task automatic run(input logic xv, input int n);
      for (int i = 0; i < n; i++) step(xv);
   endtask

   initial begin
      clear_n = 1'b0;
      x       = 1'b0;
      model_reset();
      #1;
      check_eq("rst_hwy_def", hwy_d, 3'b001);
      check_eq("rst_cty_def", cntry_d, 3'b100);
      check_eq("rst_hwy_ovr", hwy_o, 3'b001);
      check_eq("rst_cty_ovr", cntry_o, 3'b100);
      @(negedge clock);

      run(1'b0, 5);
      clear_n = 1'b1;
      run(1'b0, 14);

      run(1'b1, 12);
      run(1'b0, 8);

      for (int p = 0; p < 3; p++) begin
         run(1'b0, 20);
         run(1'b1, 10);
      end
      run(1'b0, 10);

      // Country yellow must complete even if x returns mid-yellow.
      run(1'b1, 10);
      run(1'b0, 1);
      run(1'b1, 6);
      run(1'b0, 10);

      // Asynchronous clear between edges while both instances sit in country green.
      run(1'b1, 8);
      #1 clear_n = 1'b0;
      #1;
      check_eq("async_hwy_def", hwy_d, 3'b001);
      check_eq("async_cty_def", cntry_d, 3'b100);
      check_eq("async_hwy_ovr", hwy_o, 3'b001);
      check_eq("async_cty_ovr", cntry_o, 3'b100);
      #1 clear_n = 1'b1;
      model_reset();
      run(1'b0, 10);
      run(1'b1, 8);
      run(1'b0, 10);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
